// File: rtl/unique_value_detector.sv
// First-occurrence detector over a 1-bit-per-value seen table, swept to zero after reset/clear_in.
// Result 2 cycles after transfer, one value/cycle; ready_out low only while sweeping, no result backpressure.
module unique_value_detector #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_in,
    input  logic [DATA_WIDTH-1:0] value_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  result_valid_out,
    output logic [DATA_WIDTH-1:0] result_value_out,
    output logic                  result_unique_out,
    output logic                  unique_pulse_out,
    output logic                  clearing_out
);

    localparam int DEPTH = 2 ** DATA_WIDTH;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [DATA_WIDTH:0] LAST_ADDR = (DATA_WIDTH+1)'(DEPTH - 1);

    logic [0:0]            r_state;
    logic [DATA_WIDTH:0]   r_clr_addr;
    logic                  r_a_vld;
    logic [DATA_WIDTH-1:0] r_a_val;
    logic                  r_b_vld;
    logic [DATA_WIDTH-1:0] r_b_val;
    logic                  r_b_fwd;
    logic                  r_rd_bit;
    logic                  r_res_vld;
    logic [DATA_WIDTH-1:0] r_res_val;
    logic                  r_res_uniq;
    logic                  r_seen [DEPTH];

    logic                  w_run;
    logic                  w_clr_req;
    logic                  w_xfer;
    logic                  w_seen;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_waddr;
    logic                  w_wdat;

    assign w_run     = (r_state == ST_RUN);
    assign w_clr_req = w_run && clear_in;
    assign w_xfer    = valid_in && w_run && !clear_in;
    // The read-first RAM returns stale data when the previous value is being marked this same edge.
    assign w_seen    = r_rd_bit || r_b_fwd;

    assign w_we    = !w_run || r_b_vld;
    assign w_waddr = w_run ? r_b_val : r_clr_addr[DATA_WIDTH-1:0];
    assign w_wdat  = w_run;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_seen[w_waddr] <= w_wdat;
        end
        r_rd_bit <= r_seen[r_a_val];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else if (!w_run) begin
            r_clr_addr <= r_clr_addr + (DATA_WIDTH+1)'(1);
            if (r_clr_addr == LAST_ADDR) begin
                r_state <= ST_RUN;
            end
        end else if (clear_in) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_vld <= 1'b0;
            r_a_val <= '0;
            r_b_vld <= 1'b0;
            r_b_val <= '0;
            r_b_fwd <= 1'b0;
        end else begin
            r_a_vld <= w_xfer;
            if (w_xfer) begin
                r_a_val <= value_in;
            end
            r_b_vld <= r_a_vld && !w_clr_req;
            r_b_val <= r_a_val;
            r_b_fwd <= r_a_vld && r_b_vld && (r_a_val == r_b_val);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_vld  <= 1'b0;
            r_res_val  <= '0;
            r_res_uniq <= 1'b0;
        end else begin
            r_res_vld <= r_b_vld && !w_clr_req;
            if (r_b_vld) begin
                r_res_val  <= r_b_val;
                r_res_uniq <= !w_seen;
            end
        end
    end

    assign ready_out         = w_run;
    assign clearing_out      = !w_run;
    assign result_valid_out  = r_res_vld;
    assign result_value_out  = r_res_val;
    assign result_unique_out = r_res_uniq;
    assign unique_pulse_out  = r_res_vld && r_res_uniq;

endmodule

// File: doc/unique_value_detector.md
# unique_value_detector

- Sits directly upstream of the saturating unique-value counter in the count-unique-values design.
- Accepts a stream of DATA_WIDTH-bit values and tracks which values have already appeared, using a one-bit-per-value "seen" table held in inferred block RAM.
- Emits a one-cycle pulse the first time each value appears. That pulse drives the counter's enable_in.
- After reset, and on request, it sweeps the table to zero before it accepts data.

## Interface
Parameters:
- DATA_WIDTH, 8, width of input values. Table depth is 2**DATA_WIDTH entries of 1 bit.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- clear_in  input  1  synchronous request to forget all values; sampled only in RUN.
- value_in  input  DATA_WIDTH  value to classify.
- valid_in  input  1  value_in is valid this cycle.
- ready_out  output  1  block can accept a value this cycle. A transfer occurs when valid_in && ready_out.
- result_valid_out  output  1  one-cycle strobe; a classification result is present.
- result_value_out  output  DATA_WIDTH  value the result refers to.
- result_unique_out  output  1  1 = first occurrence since the last clear; 0 = duplicate. Meaningful only with result_valid_out.
- unique_pulse_out  output  1  result_valid_out && result_unique_out; connects to the counter's enable_in.
- clearing_out  output  1  table sweep in progress.

## Operation
State machine, two states: CLEAR and RUN.
- **CLEAR:**
  - A clear address counter (DATA_WIDTH+1 bits) writes 0 to entries 0 .. 2**DATA_WIDTH-1, one per cycle.
  - ready_out=0, clearing_out=1.
  - After writing the last entry, go to RUN.
- **RUN:**
  - ready_out=1, clearing_out=0.
  - clear_in=1 → go to CLEAR with address 0. Any results in flight are discarded (result_valid_out forced 0 from the next cycle).
  - A transfer on the same cycle as clear_in is ignored.
- Entry to CLEAR is always from address 0. Async reset enters CLEAR.
- **Table:**
  - Single inferred RAM with a synchronous read port, read-first.
  - One write per cycle, shared between the sweep and marking. The two never overlap because marking happens only in RUN.
- **Pipeline:** two stages.
  - Stage A (accept cycle): issue the read at value_in and register the value and a valid bit.
  - Stage B (next cycle): the read bit is available. seen = read bit OR forwarded hazard bit.
    - Write 1 to the table at the Stage B value.
    - Register the outputs: result_unique_out = !seen.
- **Hazard forwarding:**
  - If Stage B holds a valid value equal to the value being accepted in Stage A, set the forward flag for that value. When it reaches Stage B, seen=1.
  - Covers back-to-back identical values, where the read-first RAM returns stale 0.
  - Values two or more transfers apart need no forwarding.
- Semantics must equal an ideal set: result_unique_out=1 iff the value was not transferred since the last reset/clear completion, irrespective of spacing or gaps in valid_in.

## Timing
- **Reset (async assert):**
  - State=CLEAR, clear address=0.
  - ready_out=0, clearing_out=1.
  - result_valid_out=0, result_unique_out=0, unique_pulse_out=0, result_value_out=0.
  - Pipeline valid bits=0.
- **Sweep duration:** 2**DATA_WIDTH cycles. With DATA_WIDTH=8, ready_out first goes high in the 257th cycle after the first posedge with reset low. The first 256 posedges write entries 0..255.
- **Latency:** transfer at posedge k → result_valid_out high for exactly one cycle after posedge k+2.
  - Full throughput: one value per cycle.
  - No backpressure on results.
- **clear_in in RUN at posedge k:**
  - clearing_out=1 and ready_out=0 after posedge k.
  - Transfers accepted at k-1 and k-2 produce no result.
  - Stage B marking on posedge k is still allowed, since the sweep then overwrites it.
- **Mid-sweep reset:** the sweep restarts from address 0.
- **valid_in while ready_out=0:** ignored, with no state change.

## Test plan
- **Reset and sweep:** reset for 3 cycles, release → ready_out=0 and clearing_out=1 for 256 cycles, then ready_out=1. All result outputs stay 0 throughout.
- **Distinct stream:** send values 0..255 back-to-back → 256 results with unique=1, each 2 cycles after its transfer. The counter (MAX_VALUE=256) reads 256.
- **Back-to-back duplicate:** send 5, 5, 5 consecutively → results unique=1, 0, 0. Exactly one unique_pulse_out.
- **Spaced duplicate:**
  - Send 9, 3, 9, then idle 4 cycles, then 3 → unique=1, 1, 0, 0.
  - Send 3 immediately after 9 with valid_in gaps of 1 → same answers.
- **Clear mid-stream:** send 7, 8; assert clear_in in the cycle 8 is accepted → no results for 7 and 8. After the 256-cycle sweep, send 7 → unique=1.
- **Reset mid-sweep:** assert reset at sweep cycle 100, release → a full 256-cycle sweep again. A previously marked value reported unique afterward.
